infinity_core: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle 8-bit Infinity datapath.
- Integrates PC, instruction register, 8-entry register file, ALU and control into one FSM-driven core.
- Separate instruction and data memory ports, each with a req/ready handshake, so ROM/RAM models may insert wait states.
- Adds an immediate-load fetch, halt/resume and a retire strobe for verification.

---
 rtl/infinity_core.sv | 183 ++++++++++++++++++
 tb/tb_infinity_core.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/infinity_core.sv
// infinity_core: multi-cycle 8-bit-ISA core with PC, IR, 8-entry register
// file, ALU and a FETCH/EXEC/MEM/IMM/HALTED controller. Instruction and data
// ports use req/ready handshakes so memories may insert wait states.
module infinity_core #(
    parameter int              DATA_W   = 8,
    parameter int              PC_W     = 8,
    parameter int              DADDR_W  = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               halt,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [7:0]         imem_rdata,
    input  logic               imem_ready,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic [DATA_W-1:0]  dmem_rdata,
    input  logic               dmem_ready,
    output logic [PC_W-1:0]    pc,
    output logic               halted,
    output logic               retire
);

    typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM, S_IMM, S_HALTED} state_t;
    typedef enum logic [1:0] {OP_MOV, OP_LD, OP_ST, OP_ALU} op_t;
    typedef enum logic [2:0] {
        SUB_AND, SUB_ADD, SUB_SUB, SUB_BR, SUB_BIZ, SUB_BIN, SUB_JL, SUB_LDI
    } sub_t;

    state_t              state, state_nx;
    logic                boot;        // high only in the first cycle after reset
    logic [7:0]          ir;
    logic [DATA_W-1:0]   rf [8];
    logic [PC_W-1:0]     pc_q;
    logic [DADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]   wdata_q;

    // Instruction decode and register operands.
    op_t                 op;
    sub_t                sub;
    logic [2:0]          ra, rb;
    logic [DATA_W-1:0]   r1, rra, rrb;
    logic [PC_W-1:0]     pc_inc, br_tgt;
    logic                boot_halt, is_mem, is_ldi;
    state_t              boundary;

    assign op        = op_t'(ir[7:6]);
    assign sub       = sub_t'(ir[5:3]);
    assign ra        = ir[5:3];
    assign rb        = ir[2:0];
    assign r1        = rf[1];
    assign rra       = rf[ra];
    assign rrb       = rf[rb];
    assign pc_inc    = pc_q + PC_W'(1);
    assign br_tgt    = rrb[PC_W-1:0];
    assign boot_halt = boot && halt;
    assign is_mem    = (op == OP_LD) || (op == OP_ST);
    assign is_ldi    = (op == OP_ALU) && (sub == SUB_LDI);
    // Every instruction boundary parks the core if halt is requested.
    assign boundary  = halt ? S_HALTED : S_FETCH;

    assign pc         = pc_q;
    assign imem_addr  = pc_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= state_nx;
    end

    // Next-state logic.
    // NOTE: default assignment first so no path leaves state_nx unassigned (no latch).
    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH: begin
                if (boot_halt)       state_nx = S_HALTED;
                else if (imem_ready) state_nx = S_EXEC;
            end
            S_EXEC: begin
                if (is_mem)      state_nx = S_MEM;
                else if (is_ldi) state_nx = S_IMM;
                else             state_nx = boundary;
            end
            S_MEM:    if (dmem_ready) state_nx = boundary;
            S_IMM:    if (imem_ready) state_nx = boundary;
            S_HALTED: if (!halt)      state_nx = S_FETCH;
            default:  state_nx = S_FETCH;
        endcase
    end

    // Handshake, halted and retire outputs decoded from the current state.
    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        halted   = 1'b0;
        retire   = 1'b0;
        case (state)
            // Reset parks in FETCH; keep the request low while rst is held.
            S_FETCH:  imem_req = !rst && !boot_halt;
            S_EXEC:   retire   = !is_mem && !is_ldi;
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (op == OP_ST);
                retire   = dmem_ready;
            end
            S_IMM: begin
                imem_req = 1'b1;
                retire   = imem_ready;
            end
            S_HALTED: halted = 1'b1;
            default: ;
        endcase
    end

    // Datapath: IR, register file, PC and data-access latches.
    // NOTE: the register file is reset explicitly because software may read any register before writing it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            ir      <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            boot    <= 1'b1;
            for (int i = 0; i < 8; i++) rf[i] <= '0;
        end else begin
            boot <= 1'b0;
            case (state)
                S_FETCH: if (imem_ready && !boot_halt) ir <= imem_rdata;
                S_EXEC: begin
                    case (op)
                        OP_MOV: begin
                            rf[rb] <= rra;
                            pc_q   <= pc_inc;
                        end
                        OP_LD, OP_ST: begin
                            addr_q  <= rra[DADDR_W-1:0];
                            wdata_q <= rrb;
                        end
                        default: begin
                            case (sub)
                                SUB_AND: begin rf[rb] <= rrb & r1; pc_q <= pc_inc; end
                                SUB_ADD: begin rf[rb] <= rrb + r1; pc_q <= pc_inc; end
                                SUB_SUB: begin rf[rb] <= rrb - r1; pc_q <= pc_inc; end
                                SUB_BR:  pc_q <= br_tgt;
                                SUB_BIZ: pc_q <= (r1 == '0) ? br_tgt : pc_inc;
                                SUB_BIN: pc_q <= r1[DATA_W-1] ? br_tgt : pc_inc;
                                // Target comes from the old R1 even when rb == 1.
                                SUB_JL: begin
                                    rf[rb] <= DATA_W'(pc_inc);
                                    pc_q   <= r1[PC_W-1:0];
                                end
                                default: pc_q <= pc_inc;   // LDI: step to the immediate
                            endcase
                        end
                    endcase
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        if (op == OP_LD) rf[rb] <= dmem_rdata;
                        pc_q <= pc_inc;
                    end
                end
                S_IMM: begin
                    if (imem_ready) begin
                        rf[rb] <= DATA_W'(imem_rdata);
                        pc_q   <= pc_inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_infinity_core.sv
// Testbench for infinity_core: wait-state ROM/RAM models, table-driven
// single-instruction vectors, a retire/pc scoreboard and hand-written
// sequences for reset, wait states, halt and 16-bit wrap.
module tb_infinity_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, halt = 1'b0;
    logic       imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, halted, retire;
    logic [7:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, pc;
    logic [7:0] imem [256];
    logic [7:0] dmem [256];
    int         i_wait = 0, d_wait = 0, icnt, dcnt;

    infinity_core dut (
        .clk(clk), .rst(rst), .halt(halt),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .pc(pc), .halted(halted), .retire(retire)
    );

    // Memory models: ready after a programmable number of wait cycles.
    assign imem_rdata = imem[imem_addr];
    assign imem_ready = imem_req && (icnt >= i_wait);
    assign dmem_rdata = dmem[dmem_addr];
    assign dmem_ready = dmem_req && (dcnt >= d_wait);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            icnt <= 0;
            dcnt <= 0;
        end else begin
            icnt <= (imem_req && !imem_ready) ? icnt + 1 : 0;
            dcnt <= (dmem_req && !dmem_ready) ? dcnt + 1 : 0;
        end
    end

    always @(posedge clk) begin
        if (dmem_req && dmem_we && dmem_ready) dmem[dmem_addr] <= dmem_wdata;
    end

    // 16-bit instance with a zero-wait ROM for the wrap test.
    logic        rst16 = 1'b1, halt16 = 1'b0;
    logic        imem_req16, dmem_req16, dmem_we16, halted16, retire16;
    logic [7:0]  imem_addr16, imem_rdata16, dmem_addr16, pc16;
    logic [15:0] dmem_wdata16;
    logic [7:0]  imem16 [256];

    assign imem_rdata16 = imem16[imem_addr16];

    infinity_core #(.DATA_W(16)) dut16 (
        .clk(clk), .rst(rst16), .halt(halt16),
        .imem_req(imem_req16), .imem_addr(imem_addr16), .imem_rdata(imem_rdata16), .imem_ready(imem_req16),
        .dmem_req(dmem_req16), .dmem_we(dmem_we16), .dmem_addr(dmem_addr16), .dmem_wdata(dmem_wdata16),
        .dmem_rdata(16'h0000), .dmem_ready(dmem_req16),
        .pc(pc16), .halted(halted16), .retire(retire16)
    );

    int         n_checks = 0, n_pass = 0;
    logic [7:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic hold_reset();
        rst = 1'b1;
        for (int k = 0; k < 256; k++) imem[k] = 8'h00;
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic load(input logic [7:0] bytes [$]);
        for (int k = 0; k < bytes.size(); k++) imem[k] = bytes[k];
    endtask

    task automatic release_reset(input int iw, input int dw);
        i_wait = iw;
        d_wait = dw;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Run until n retires; each retire pops the expected pc from the scoreboard.
    task automatic run(input int n, output int used, output int last_at);
        int got = 0;
        bit pend = 1'b0;
        used = 0;
        last_at = 0;
        while ((got < n || pend) && used < 300) begin
            @(negedge clk);
            used++;
            if (pend) begin
                pend = 1'b0;
                if (exp_q.size() > 0) check("retire_pc", pc, exp_q.pop_front());
                else begin
                    n_checks++;
                    $display("FAIL retire_pc: retire with empty scoreboard, pc 0x%0h", pc);
                end
            end
            if (got < n && retire) begin
                got++;
                pend = 1'b1;
                last_at = used;
            end
        end
        if (got < n || pend) begin
            n_checks++;
            $display("FAIL run_timeout: %0d of %0d retires seen", got, n);
        end
    endtask

    task automatic wait_dreq(input string name);
        for (int k = 0; k < 20 && !dmem_req; k++) @(negedge clk);
        check(name, dmem_req, 1);
    endtask

    typedef struct {
        logic [7:0] a;     // loaded into R1
        logic [7:0] b;     // loaded into R2
        logic [7:0] ins;   // instruction under test at pc 4
        int         chk;   // register to inspect
        logic [7:0] ev;    // expected register value
        logic [7:0] epc;   // expected pc after the instruction
    } vec_t;

    vec_t vecs [12];
    int   used, last_at, used_a;
    bit   seen;

    initial begin
        vecs[0]  = '{8'h05, 8'h03, 8'hCA, 2, 8'h08, 8'h05};   // ADD R2
        vecs[1]  = '{8'h05, 8'h03, 8'hD2, 2, 8'hFE, 8'h05};   // SUB R2
        vecs[2]  = '{8'h0F, 8'h3C, 8'hC2, 2, 8'h0C, 8'h05};   // AND R2
        vecs[3]  = '{8'h11, 8'h77, 8'h13, 3, 8'h77, 8'h05};   // MOV R2->R3
        vecs[4]  = '{8'h00, 8'h40, 8'hE2, 2, 8'h40, 8'h40};   // BIZ taken
        vecs[5]  = '{8'h01, 8'h40, 8'hE2, 2, 8'h40, 8'h05};   // BIZ not taken
        vecs[6]  = '{8'h80, 8'h40, 8'hEA, 2, 8'h40, 8'h40};   // BIN taken
        vecs[7]  = '{8'h7F, 8'h40, 8'hEA, 2, 8'h40, 8'h05};   // BIN not taken
        vecs[8]  = '{8'h00, 8'h33, 8'hDA, 2, 8'h33, 8'h33};   // BR R2
        vecs[9]  = '{8'h20, 8'h00, 8'hF5, 5, 8'h05, 8'h20};   // JL R5
        vecs[10] = '{8'h20, 8'h00, 8'hF1, 1, 8'h05, 8'h20};   // JL R1: old R1 is target
        vecs[11] = '{8'h01, 8'hFF, 8'hCA, 2, 8'h00, 8'h05};   // ADD wrap

        // Reset state.
        hold_reset();
        check("rst_pc", pc, 8'h00);
        check("rst_imem_req", imem_req, 0);
        check("rst_dmem_req", dmem_req, 0);
        check("rst_halted", halted, 0);
        check("rst_retire", retire, 0);

        // Table-driven single instructions, varying instruction wait states.
        foreach (vecs[i]) begin
            hold_reset();
            load({8'hF9, vecs[i].a, 8'hFA, vecs[i].b, vecs[i].ins});
            exp_q.push_back(8'h02);
            exp_q.push_back(8'h04);
            exp_q.push_back(vecs[i].epc);
            release_reset(i % 3, 0);
            run(3, used, last_at);
            check($sformatf("vec%0d_r%0d", i, vecs[i].chk), dut.rf[vecs[i].chk], vecs[i].ev);
        end

        // LDI R1,5; LDI R2,3; ADD R2; SUB R2 with zero wait: last retire in cycle 10.
        hold_reset();
        load({8'hF9, 8'h05, 8'hFA, 8'h03, 8'hCA, 8'hD2});
        exp_q = {8'h02, 8'h04, 8'h05, 8'h06};
        release_reset(0, 0);
        run(3, used_a, last_at);
        check("prog_add_r2", dut.rf[2], 8'h08);
        run(1, used, last_at);
        check("prog_sub_r2", dut.rf[2], 8'h03);
        check("prog_latency", used_a + last_at, 9);

        // Reset in the middle of a stalled LD.
        hold_reset();
        load({8'hF9, 8'h10, 8'h4A});
        exp_q.push_back(8'h02);
        release_reset(0, 5);
        run(1, used, last_at);
        wait_dreq("midmem_req_seen");
        rst = 1'b1;
        #1;
        check("midmem_dmem_req", dmem_req, 0);
        check("midmem_pc", pc, 8'h00);
        for (int r = 0; r < 8; r++) check($sformatf("midmem_r%0d", r), dut.rf[r], 8'h00);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midmem_refetch_req", imem_req, 1);
        check("midmem_refetch_addr", imem_addr, 8'h00);
        exp_q.push_back(8'h02);
        run(1, used, last_at);
        check("midmem_rerun_r1", dut.rf[1], 8'h10);

        // ST with 3 wait states holds address and data for 4 cycles, then LD back.
        hold_reset();
        load({8'hFA, 8'h10, 8'hFB, 8'hAB, 8'h93, 8'h54});
        exp_q = {8'h02, 8'h04};
        release_reset(0, 3);
        run(2, used, last_at);
        wait_dreq("st_req_seen");
        for (int k = 0; k < 4; k++) begin
            check($sformatf("st_hold%0d_req", k), dmem_req, 1);
            check($sformatf("st_hold%0d_we", k), dmem_we, 1);
            check($sformatf("st_hold%0d_addr", k), dmem_addr, 8'h10);
            check($sformatf("st_hold%0d_wdata", k), dmem_wdata, 8'hAB);
            check($sformatf("st_hold%0d_ready", k), dmem_ready, (k == 3));
            check($sformatf("st_hold%0d_retire", k), retire, (k == 3));
            @(negedge clk);
        end
        check("st_pc", pc, 8'h05);
        check("st_mem", dmem[8'h10], 8'hAB);
        exp_q.push_back(8'h06);
        run(1, used, last_at);
        check("ld_r4", dut.rf[4], 8'hAB);

        // JL R5 at pc 0x07 with R1 = 0x20.
        hold_reset();
        load({8'hF9, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF5});
        exp_q = {8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h20};
        release_reset(1, 0);
        run(7, used, last_at);
        check("jl7_r5", dut.rf[5], 8'h08);

        // Halt raised during LD wait states: LD completes, then the core parks.
        hold_reset();
        load({8'hF9, 8'h10, 8'hFA, 8'h5A, 8'h8A, 8'h4B, 8'hFC, 8'h07});
        exp_q = {8'h02, 8'h04, 8'h05};
        release_reset(0, 3);
        run(3, used, last_at);
        wait_dreq("halt_ld_req_seen");
        halt = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = retire;
        end
        check("halt_ld_retire", seen, 1);
        @(negedge clk);
        check("halt_halted", halted, 1);
        check("halt_imem_req", imem_req, 0);
        check("halt_dmem_req", dmem_req, 0);
        check("halt_pc", pc, 8'h06);
        check("halt_ld_r3", dut.rf[3], 8'h5A);
        repeat (3) @(negedge clk);
        check("halt_still_parked", halted, 1);
        halt = 1'b0;
        @(negedge clk);
        check("resume_halted", halted, 0);
        check("resume_imem_req", imem_req, 1);
        check("resume_imem_addr", imem_addr, 8'h06);
        exp_q.push_back(8'h08);
        run(1, used, last_at);
        check("resume_r4", dut.rf[4], 8'h07);

        // Halt held through reset release parks before the first fetch.
        hold_reset();
        halt = 1'b1;
        release_reset(0, 0);
        #1;
        check("boot_halt_imem_req", imem_req, 0);
        @(negedge clk);
        check("boot_halt_halted", halted, 1);
        halt = 1'b0;
        @(negedge clk);
        check("boot_resume_imem_req", imem_req, 1);
        check("boot_resume_addr", imem_addr, 8'h00);

        // DATA_W = 16: R0 = 0 - 1 = 0xFFFF, R3 = R0, ADD R3 wraps to 0.
        rst = 1'b1;
        for (int k = 0; k < 256; k++) imem16[k] = 8'h00;
        imem16[0] = 8'hF9; imem16[1] = 8'h01; imem16[2] = 8'hD0;
        imem16[3] = 8'h03; imem16[4] = 8'hCB;
        @(negedge clk);
        rst16 = 1'b0;
        repeat (14) @(negedge clk);
        check("w16_r1", dut16.rf[1], 16'h0001);
        check("w16_r0", dut16.rf[0], 16'hFFFF);
        check("w16_r3_wrap", dut16.rf[3], 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
